// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous square wave, counted in clk_in cycles.
// Publishes one measurement per input cycle with a valid strobe and flags signal loss by timeout.
module period_meter #(
   parameter int          CNT_W   = 32,
   parameter logic [31:0] TIMEOUT = 32'd1000000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             valid_out,
   output logic             locked_out,
   output logic             timeout_out
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] MEASURE = 1'b1;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic             s1_q, s2_q, s3_q;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_high_q, hold_high_d;
   logic             fall_seen_q, fall_seen_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;
   logic             rise, fall;

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_high_d = hold_high_q;
      fall_seen_d = fall_seen_q;
      period_d    = period_q;
      high_d      = high_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      timeout_d   = timeout_q;

      // Saturating counter, restarted at 1 on every detected rise.
      if (rise) begin
         cnt_d = ONE_C;
      end else if (!(&cnt_q)) begin
         cnt_d = cnt_q + ONE_C;
      end

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d     = MEASURE;
               fall_seen_d = 1'b0;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_d    = cnt_q;
               high_d      = fall_seen_q ? hold_high_q : cnt_q;
               valid_d     = 1'b1;
               locked_d    = 1'b1;
               timeout_d   = 1'b0;
               fall_seen_d = 1'b0;
            end else begin
               if (fall) begin
                  hold_high_d = cnt_q;
                  fall_seen_d = 1'b1;
               end
               // A timeout before the first lock is not a loss of signal, so only a
               // locked meter raises the flag; either way we fall back to IDLE.
               if (cnt_q == TIMEOUT_C) begin
                  timeout_d = timeout_q | locked_q;
                  locked_d  = 1'b0;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_high_q <= '0;
         fall_seen_q <= 1'b0;
         period_q    <= '0;
         high_q      <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         s1_q        <= sig_in;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_high_q <= hold_high_d;
         fall_seen_q <= fall_seen_d;
         period_q    <= period_d;
         high_q      <= high_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
      end
   end

   assign period_out  = period_q;
   assign high_out    = high_q;
   assign valid_out   = valid_q;
   assign locked_out  = locked_q;
   assign timeout_out = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT=1000: expected measurements are queued
// as stimulus is issued and popped by a monitor on every valid_out.
module tb_period_meter;

   localparam int W = 32;

   logic         clk_in = 1'b0;
   logic         rst    = 1'b1;
   logic         sig_in = 1'b0;
   logic [W-1:0] period_out, high_out;
   logic         valid_out, locked_out, timeout_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_valid_cyc = 0;
   bit jit_en = 1'b0;

   logic [2*W-1:0] exp_q[$];

   period_meter #(.CNT_W(W), .TIMEOUT(32'd1000)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .sig_in      (sig_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .valid_out   (valid_out),
      .locked_out  (locked_out),
      .timeout_out (timeout_out)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk_in);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk_in);
      #2 rst = 1'b0;
   endtask

   // ---------------- checking ----------------
   function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_sig(input logic v);
      @(posedge clk_in);
      if (jit_en) #($urandom_range(1, 8));
      else #1;
      sig_in = v;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_in);
   endtask

   task automatic pulse(input int h, input int l);
      set_sig(1'b1);
      wait_edges(h - 1);
      set_sig(1'b0);
      wait_edges(l - 1);
   endtask

   task automatic push_exp(input int p, input int h);
      exp_q.push_back({W'(p), W'(h)});
   endtask

   task automatic wait_timeout(input int expect_delta);
      int n = 0;
      while (timeout_out !== 1'b1 && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      if (timeout_out !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL timeout_wait: timeout_out never rose, expected after %0d cycles", expect_delta);
      end else begin
         check("timeout_delay", W'(cyc - last_valid_cyc), W'(expect_delta));
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_in) begin
      if (!rst && valid_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: period %0d high %0d, expected no valid (cycle %0d)",
                     period_out, high_out, cyc);
         end else begin
            logic [2*W-1:0] e;
            e = exp_q.pop_front();
            check("period", period_out, e[2*W-1:W]);
            check("high", high_out, e[W-1:0]);
         end
         last_valid_cyc = cyc;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      #1;
      check("rst_period", period_out, '0);
      check("rst_high", high_out, '0);
      check("rst_valid", W'(valid_out), '0);
      check("rst_locked", W'(locked_out), '0);
      check("rst_timeout", W'(timeout_out), '0);
      wait_edges(3);
      #2 rst = 1'b0;

      // 50% duty, period 500: first rise only arms the meter
      for (int i = 0; i < 5; i++) begin
         if (i > 0) push_exp(500, 250);
         pulse(250, 250);
      end
      check("t1_locked", W'(locked_out), 1);
      check("t1_timeout", W'(timeout_out), 0);

      // 37 high / 63 low with sub-cycle phase jitter on every edge
      do_reset();
      jit_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) push_exp(100, 37);
         pulse(37, 63);
      end
      jit_en = 1'b0;
      check("t2_locked", W'(locked_out), 1);

      // period 200 then signal lost: timeout 1000 cycles after last measurement
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) push_exp(200, 100);
         pulse(100, 100);
      end
      push_exp(200, 100);
      set_sig(1'b1);
      wait_edges(99);
      set_sig(1'b0);
      wait_timeout(1000);
      check("t3_locked_lost", W'(locked_out), 0);
      check("t3_period_held", period_out, 200);
      check("t3_high_held", high_out, 100);
      wait_edges(50);
      check("t3_timeout_sticky", W'(timeout_out), 1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) push_exp(200, 100);
         pulse(100, 100);
      end
      check("t3_timeout_clr", W'(timeout_out), 0);
      check("t3_relocked", W'(locked_out), 1);

      // static high from reset never locks, never times out
      sig_in = 1'b1;
      do_reset();
      wait_edges(1500);
      check("t4_locked", W'(locked_out), 0);
      check("t4_timeout", W'(timeout_out), 0);
      set_sig(1'b0);
      wait_edges(1500);
      check("t4_locked_fall", W'(locked_out), 0);
      check("t4_timeout_fall", W'(timeout_out), 0);

      // asynchronous reset mid-period while locked
      do_reset();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) push_exp(200, 100);
         pulse(100, 100);
      end
      push_exp(200, 100);
      set_sig(1'b1);
      wait_edges(99);
      set_sig(1'b0);
      wait_edges(50);
      check("t5_locked_before", W'(locked_out), 1);
      @(posedge clk_in);
      #3 rst = 1'b1;
      #1;
      check("t5_async_period", period_out, '0);
      check("t5_async_high", high_out, '0);
      check("t5_async_valid", W'(valid_out), '0);
      check("t5_async_locked", W'(locked_out), '0);
      check("t5_async_timeout", W'(timeout_out), '0);
      wait_edges(2);
      #2 rst = 1'b0;
      push_exp(200, 100);
      pulse(100, 100);
      pulse(100, 100);
      check("t5_relocked", W'(locked_out), 1);

      // period equal to TIMEOUT: the rise wins over the timeout
      do_reset();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) push_exp(1000, 500);
         pulse(500, 500);
      end
      push_exp(1000, 500);
      set_sig(1'b1);
      wait_edges(10);
      check("t6_timeout", W'(timeout_out), 0);
      check("t6_locked", W'(locked_out), 1);
      check("t6_period", period_out, 1000);

      wait_edges(10);
      check("queue_drained", W'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
